// File: rtl/mpa_rf_wb_arbiter_pkg.sv
// mpa_rf_pkg: shared widths, requester ids and round-robin state encoding for the writeback arbiter
package mpa_rf_pkg;
    localparam int MPA_RF_AW = 5;
    localparam int MPA_RF_DW = 32;
    localparam logic [MPA_RF_AW-1:0] MPA_RF_ZERO = 5'd0;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;
    typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} rr_state_t;
endpackage

// File: rtl/mpa_rf_wb_arbiter_if.sv
// mpa_rf_wb_arbiter_if: writeback requests, register-file write port and hazard-check signals
//   alu_*/mem_* : valid/ready handshake with destination addr and data per requester
//   rf_*        : register file write port (we, a2, din)
//   chk_*       : two read addresses in, pending-write hazard flags out
//   r0_drop     : pulse when a write to $zero was discarded
interface mpa_rf_wb_arbiter_if import mpa_rf_pkg::*; #(
    parameter int AW = MPA_RF_AW,
    parameter int DW = MPA_RF_DW
);
    logic          alu_valid, alu_ready, mem_valid, mem_ready;
    logic [AW-1:0] alu_addr, mem_addr, rf_a2, chk_a0, chk_a1;
    logic [DW-1:0] alu_data, mem_data, rf_din;
    logic          rf_we, chk_haz0, chk_haz1, r0_drop;
    modport slave (
        input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, chk_a0, chk_a1,
        output alu_ready, mem_ready, rf_we, rf_a2, rf_din, chk_haz0, chk_haz1, r0_drop
    );
    modport master (
        output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data, chk_a0, chk_a1,
        input  alu_ready, mem_ready, rf_we, rf_a2, rf_din, chk_haz0, chk_haz1, r0_drop
    );
endinterface

// File: rtl/mpa_wb_hold_slot.sv
// mpa_wb_hold_slot: one-entry writeback holding slot
//   accept/in_addr/in_data : handshake fire and payload; $zero payloads are dropped (zero=1)
//   clear                  : slot is being written to the register file this cycle
//   valid/addr/data        : held entry; load pulses when an entry is captured
//   hit0/hit1              : held entry targets chk_a0/chk_a1 (never for $zero)
module mpa_wb_hold_slot import mpa_rf_pkg::*; #(
    parameter int AW = MPA_RF_AW,
    parameter int DW = MPA_RF_DW
) (
    input  logic          clk,
    input  logic          hw_rst_n,
    input  logic          accept,
    input  logic          clear,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic [AW-1:0] chk_a0,
    input  logic [AW-1:0] chk_a1,
    output logic          valid,
    output logic          load,
    output logic          zero,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          hit0,
    output logic          hit1
);
    assign zero = accept && in_addr == AW'(MPA_RF_ZERO);
    assign load = accept && !zero;
    always_ff @(posedge clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else begin
            valid <= load || (valid && !clear);
            if (load) begin
                addr <= in_addr;
                data <= in_data;
            end
        end
    end
    assign hit0 = valid && addr == chk_a0 && chk_a0 != AW'(MPA_RF_ZERO);
    assign hit1 = valid && addr == chk_a1 && chk_a1 != AW'(MPA_RF_ZERO);
endmodule

// File: rtl/mpa_rf_wb_arbiter.sv
// mpa_rf_wb_arbiter: shares the register file write port between ALU and MEM writeback slots
//   clk      : clock, rising edge
//   hw_rst_n : asynchronous active-low reset
//   bus      : slave side of mpa_rf_wb_arbiter_if (requests, rf write port, hazards, r0_drop)
module mpa_rf_wb_arbiter import mpa_rf_pkg::*; #(
    parameter int AW = MPA_RF_AW,
    parameter int DW = MPA_RF_DW
) (
    input logic clk,
    input logic hw_rst_n,
    mpa_rf_wb_arbiter_if.slave bus
);
    logic          alu_v, alu_ld, alu_zr, alu_h0, alu_h1;
    logic          mem_v, mem_ld, mem_zr, mem_h0, mem_h1;
    logic [AW-1:0] alu_a, mem_a;
    logic [DW-1:0] alu_d, mem_d;
    logic          any, gnt_mem, age_mem, r0_q;
    rr_state_t     ptr, ptr_nxt;

    mpa_wb_hold_slot #(.AW(AW), .DW(DW)) u_alu (
        .clk, .hw_rst_n,
        .accept(bus.alu_valid && bus.alu_ready), .clear(alu_v && !gnt_mem),
        .in_addr(bus.alu_addr), .in_data(bus.alu_data),
        .chk_a0(bus.chk_a0), .chk_a1(bus.chk_a1),
        .valid(alu_v), .load(alu_ld), .zero(alu_zr), .addr(alu_a), .data(alu_d),
        .hit0(alu_h0), .hit1(alu_h1)
    );
    mpa_wb_hold_slot #(.AW(AW), .DW(DW)) u_mem (
        .clk, .hw_rst_n,
        .accept(bus.mem_valid && bus.mem_ready), .clear(gnt_mem),
        .in_addr(bus.mem_addr), .in_data(bus.mem_data),
        .chk_a0(bus.chk_a0), .chk_a1(bus.chk_a1),
        .valid(mem_v), .load(mem_ld), .zero(mem_zr), .addr(mem_a), .data(mem_d),
        .hit0(mem_h0), .hit1(mem_h1)
    );

    // Same-register conflicts go by age so per-register order holds; otherwise round-robin,
    // with the pointer left on the side that was not just served.
    always_comb begin
        ptr_nxt = ptr;
        gnt_mem = 1'b0;
        if (alu_v && mem_v) begin
            if (alu_a == mem_a) begin
                gnt_mem = age_mem;
            end else begin
                gnt_mem = ptr == PRI_MEM;
                ptr_nxt = gnt_mem ? PRI_ALU : PRI_MEM;
            end
        end else if (alu_v || mem_v) begin
            gnt_mem = mem_v;
            ptr_nxt = mem_v ? PRI_ALU : PRI_MEM;
        end
    end

    // age_mem=1 means the MEM slot holds the older entry; a freshly loaded slot is always younger,
    // and a simultaneous load of both marks MEM older.
    always_ff @(posedge clk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            ptr     <= PRI_ALU;
            age_mem <= 1'b0;
            r0_q    <= 1'b0;
        end else begin
            ptr     <= ptr_nxt;
            age_mem <= alu_ld ? 1'b1 : mem_ld ? 1'b0 : age_mem;
            r0_q    <= alu_zr || mem_zr;
        end
    end

    assign any           = alu_v || mem_v;
    assign bus.alu_ready = !alu_v || !gnt_mem;
    assign bus.mem_ready = !mem_v || gnt_mem;
    assign bus.rf_we     = any;
    assign bus.rf_a2     = !any ? '0 : gnt_mem ? mem_a : alu_a;
    assign bus.rf_din    = !any ? '0 : gnt_mem ? mem_d : alu_d;
    assign bus.chk_haz0  = alu_h0 || mem_h0;
    assign bus.chk_haz1  = alu_h1 || mem_h1;
    assign bus.r0_drop   = r0_q;
endmodule

// File: tb/tb_mpa_rf_wb_arbiter.sv
// tb_mpa_rf_wb_arbiter: table-driven cycle vectors plus a write-order scoreboard for the arbiter
module tb_mpa_rf_wb_arbiter;
    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  c0, c1;
        logic [2:0]  push;
        logic        e_ar, e_mr, e_we;
        logic [4:0]  e_a2;
        logic [31:0] e_din;
        logic        e_h0, e_h1, e_drop;
    } vec_t;

    localparam int NV = 21;

    logic clk = 1'b0;
    logic hw_rst_n;
    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];
    vec_t tbl[NV];
    vec_t t;

    mpa_rf_wb_arbiter_if bus();
    mpa_rf_wb_arbiter dut (.clk(clk), .hw_rst_n(hw_rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int rst, av, aa, input logic [31:0] ad,
                                input int mv, ma, input logic [31:0] md,
                                input int c0, c1, push, ar, mr, we, a2, input logic [31:0] din,
                                input int h0, h1, drop);
        vec_t v;
        v.rst = rst[0]; v.av = av[0]; v.aa = aa[4:0]; v.ad = ad;
        v.mv = mv[0]; v.ma = ma[4:0]; v.md = md;
        v.c0 = c0[4:0]; v.c1 = c1[4:0]; v.push = push[2:0];
        v.e_ar = ar[0]; v.e_mr = mr[0]; v.e_we = we[0]; v.e_a2 = a2[4:0]; v.e_din = din;
        v.e_h0 = h0[0]; v.e_h1 = h1[0]; v.e_drop = drop[0];
        return v;
    endfunction

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
        bus.chk_a0 = '0; bus.chk_a1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        hw_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 hw_rst_n = 1'b1;
    endtask

    task automatic chk_outs(input string p, input logic ar, mr, we, input logic [4:0] a2,
                            input logic [31:0] din, input logic h0, h1, drop);
        chk({p, "_alu_ready"}, 32'(bus.alu_ready), 32'(ar));
        chk({p, "_mem_ready"}, 32'(bus.mem_ready), 32'(mr));
        chk({p, "_rf_we"},     32'(bus.rf_we),     32'(we));
        chk({p, "_rf_a2"},     32'(bus.rf_a2),     32'(a2));
        chk({p, "_rf_din"},    bus.rf_din,         din);
        chk({p, "_haz0"},      32'(bus.chk_haz0),  32'(h0));
        chk({p, "_haz1"},      32'(bus.chk_haz1),  32'(h1));
        chk({p, "_r0_drop"},   32'(bus.r0_drop),   32'(drop));
    endtask

    // Every register-file write must match the next expected {addr,data} in order.
    always @(negedge clk) begin
        if (bus.rf_we) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got r%0d=0x%0h, want no write", bus.rf_a2, bus.rf_din);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.rf_a2), 32'(e[36:32]));
                chk("wr_data", bus.rf_din, e[31:0]);
            end
        end
    end

    initial begin
        //              rst av aa ad            mv ma md     c0 c1 push ar mr we a2 din           h0 h1 drop
        tbl[0]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     5, 0, 1,   1, 1, 0, 0, 0,            0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,            0, 0, 0,     5, 0, 0,   1, 1, 1, 5, 32'hDEADBEEF, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0,            0, 0, 0,     5, 0, 0,   1, 1, 0, 0, 0,            0, 0, 0);
        tbl[3]  = mk(1, 1, 3, 32'h11,       1, 4, 32'h22, 3, 4, 3,  1, 1, 0, 0, 0,            0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,            0, 0, 0,     3, 4, 0,   1, 0, 1, 3, 32'h11,       1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0,            0, 0, 0,     3, 4, 0,   1, 1, 1, 4, 32'h22,       0, 1, 0);
        tbl[6]  = mk(0, 1, 8, 32'h33,       1, 9, 32'h44, 0, 0, 3,  1, 1, 0, 0, 0,            0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0,   1, 0, 1, 8, 32'h33,       0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0,   1, 1, 1, 9, 32'h44,       0, 0, 0);
        tbl[9]  = mk(0, 1, 7, 32'hBB,       1, 7, 32'hAA, 7, 0, 4,  1, 1, 0, 0, 0,            0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,            0, 0, 0,     7, 0, 0,   0, 1, 1, 7, 32'hAA,       1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,            0, 0, 0,     7, 0, 0,   1, 1, 1, 7, 32'hBB,       1, 0, 0);
        tbl[12] = mk(0, 1, 1, 32'h101,      0, 0, 0,     1, 0, 1,   1, 1, 0, 0, 0,            0, 0, 0);
        tbl[13] = mk(0, 1, 2, 32'h102,      0, 0, 0,     1, 0, 1,   1, 1, 1, 1, 32'h101,      1, 0, 0);
        tbl[14] = mk(0, 1, 3, 32'h103,      0, 0, 0,     1, 0, 1,   1, 1, 1, 2, 32'h102,      0, 0, 0);
        tbl[15] = mk(0, 1, 4, 32'h104,      0, 0, 0,     3, 4, 1,   1, 1, 1, 3, 32'h103,      1, 0, 0);
        tbl[16] = mk(0, 0, 0, 0,            0, 0, 0,     4, 0, 0,   1, 1, 1, 4, 32'h104,      1, 0, 0);
        tbl[17] = mk(0, 0, 0, 0,            0, 0, 0,     4, 0, 0,   1, 1, 0, 0, 0,            0, 0, 0);
        tbl[18] = mk(0, 0, 0, 0,            1, 0, 32'h55, 0, 0, 0,  1, 1, 0, 0, 0,            0, 0, 0);
        tbl[19] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0,   1, 1, 0, 0, 0,            0, 0, 1);
        tbl[20] = mk(0, 0, 0, 0,            0, 0, 0,     0, 0, 0,   1, 1, 0, 0, 0,            0, 0, 0);

        // Reset held with an ALU request pending: outputs stay at reset values.
        idle_inputs();
        hw_rst_n = 1'b1;
        #2 hw_rst_n = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd5; bus.alu_data = 32'h1234; bus.chk_a0 = 5'd5;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_outs($sformatf("rst%0d", c), 1, 1, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        bus.alu_valid = 1'b0;
        hw_rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rf_we", 32'(bus.rf_we), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            t = tbl[i];
            if (t.rst) do_reset();
            bus.alu_valid = t.av; bus.alu_addr = t.aa; bus.alu_data = t.ad;
            bus.mem_valid = t.mv; bus.mem_addr = t.ma; bus.mem_data = t.md;
            bus.chk_a0 = t.c0; bus.chk_a1 = t.c1;
            case (t.push)
                3'd1: exp_q.push_back({t.aa, t.ad});
                3'd2: exp_q.push_back({t.ma, t.md});
                3'd3: begin exp_q.push_back({t.aa, t.ad}); exp_q.push_back({t.ma, t.md}); end
                3'd4: begin exp_q.push_back({t.ma, t.md}); exp_q.push_back({t.aa, t.ad}); end
                default: ;
            endcase
            @(negedge clk);
            chk_outs($sformatf("v%0d", i), t.e_ar, t.e_mr, t.e_we, t.e_a2, t.e_din, t.e_h0, t.e_h1, t.e_drop);
            @(posedge clk); #1;
        end

        // Fill both slots, then reset before the register file can take either entry.
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd10; bus.alu_data = 32'hA0A0_0010;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd11; bus.mem_data = 32'hB0B0_0011;
        bus.chk_a0 = 5'd10; bus.chk_a1 = 5'd11;
        @(negedge clk);
        chk("fill_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("fill_mem_ready", 32'(bus.mem_ready), 32'd1);
        @(posedge clk); #1;
        chk("full_haz0", 32'(bus.chk_haz0), 32'd1);
        chk("full_haz1", 32'(bus.chk_haz1), 32'd1);
        hw_rst_n = 1'b0;
        bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
        @(negedge clk);
        chk_outs("midrst", 1, 1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        hw_rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_outs($sformatf("post%0d", c), 1, 1, 0, 0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
